// File: rtl/bcd2b_sr.sv
// bcd2b_sr -- change-triggered three-digit BCD to binary converter.
//
// The input is resampled every cycle. When it changes, a conversion starts.
// The conversion runs a serial reverse double-dabble of NSTEP steps. The
// result is then saturated to 8 bits and presented with a one-cycle rdy
// pulse. If the input changes mid-conversion, the conversion restarts and
// the stale result is dropped.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   bdc   in   12-bit BCD value {hundreds, tens, units}
//   bc    out  8-bit binary result (saturated at 255), registered
//   ovf   out  last converted value exceeded 255, registered
//   err   out  last captured value had a digit above 9, registered
//   busy  out  converter FSM not idle
//   rdy   out  one-cycle pulse when bc/ovf/err update
module bcd2b_sr #(
  parameter int NSTEP = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bdc,
  output logic [7:0]  bc,
  output logic        ovf,
  output logic        err,
  output logic        busy,
  output logic        rdy
);

  localparam int CW = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [11:0]       bdc_q1;
  logic [11:0]       bdc_q2;
  logic              load;
  logic [11:0]       bcd_work;
  logic [NSTEP-1:0]  bin_work;
  logic [CW-1:0]     step;
  logic              err_flag;
  logic [11+NSTEP:0] shifted;

  // Reverse double-dabble correction: any digit >= 8 after the right shift
  // had carried a 10 into the half weight, so subtract 3.
  function automatic logic [11:0] dabble_adj(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd8) r[i*4 +: 4] = r[i*4 +: 4] - 4'd3;
    end
    return r;
  endfunction

  // Saturate the converted value to the 8-bit output range.
  function automatic logic [7:0] sat8(input logic [NSTEP-1:0] v);
    if (32'(v) > 255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic digit_bad(input logic [11:0] d);
    return (d[3:0] > 4'd9) || (d[7:4] > 4'd9) || (d[11:8] > 4'd9);
  endfunction

  assign shifted = {bcd_work, bin_work} >> 1;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      SHIFT:   if (step == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A fresh input change overrides whatever the FSM was doing.
    if (load) state_nxt = SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Input sampling / change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdc_q1 <= '0;
      bdc_q2 <= '0;
      load   <= 1'b0;
    end else begin
      bdc_q1 <= bdc;
      bdc_q2 <= bdc_q1;
      load   <= (bdc_q1 != bdc_q2);
    end
  end

  // Conversion datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_work <= '0;
      bin_work <= '0;
      step     <= '0;
      err_flag <= 1'b0;
      bc       <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (load) begin
        bcd_work <= bdc_q2;
        bin_work <= '0;
        step     <= '0;
        err_flag <= digit_bad(bdc_q2);
      end else begin
        case (state)
          SHIFT: begin
            bcd_work <= dabble_adj(shifted[11+NSTEP:NSTEP]);
            bin_work <= shifted[NSTEP-1:0];
            step     <= step + 1'b1;
          end
          DONE: begin
            rdy <= 1'b1;
            if (err_flag) begin
              bc  <= '0;
              ovf <= 1'b0;
              err <= 1'b1;
            end else begin
              bc  <= sat8(bin_work);
              ovf <= (32'(bin_work) > 255);
              err <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd2b_sr.sv
// Testbench for bcd2b_sr: directed scenarios, random values and a full
// sweep of valid BCD codes, checked against an arithmetic reference.
module tb_bcd2b_sr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] bdc = 12'h000;
  logic [7:0]  bc;
  logic        ovf;
  logic        err;
  logic        busy;
  logic        rdy;

  int checks   = 0;
  int failures = 0;

  bcd2b_sr #(.NSTEP(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .bdc  (bdc),
    .bc   (bc),
    .ovf  (ovf),
    .err  (err),
    .busy (busy),
    .rdy  (rdy)
  );

  always #5 clk = ~clk;

  // Reference model: decimal arithmetic from the three digits.
  function automatic bit m_err(input logic [11:0] v);
    return (v[3:0] > 9) || (v[7:4] > 9) || (v[11:8] > 9);
  endfunction
  function automatic int m_val(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic logic [7:0] m_bc(input logic [11:0] v);
    if (m_err(v)) return 8'd0;
    return (m_val(v) > 255) ? 8'd255 : 8'(m_val(v));
  endfunction
  function automatic logic m_ovf(input logic [11:0] v);
    return !m_err(v) && (m_val(v) > 255);
  endfunction
  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'((n / 100) % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply v and observe for ncyc edges. Reports the edge of the first rdy, the rdy
  // count, the busy-cycle count and whether bc changed outside an rdy cycle.
  task automatic run_value(input logic [11:0] v, input int ncyc,
                           output int lat, output int nrdy, output int nbusy,
                           output bit bad_upd);
    logic [7:0] prev;
    prev = bc;
    lat = -1; nrdy = 0; nbusy = 0; bad_upd = 0;
    bdc = v;
    for (int e = 1; e <= ncyc; e++) begin
      tick();
      if (rdy) begin
        nrdy++;
        if (lat < 0) lat = e;
      end
      if (busy) nbusy++;
      if (bc !== prev && !rdy) bad_upd = 1;
      prev = bc;
    end
  endtask

  task automatic check_result(input string name, input logic [11:0] v, input int nrdy);
    checks++;
    if (nrdy !== 1) begin
      failures++;
      $display("FAIL %s rdy_pulses v=%h got=%0d want=1", name, v, nrdy);
    end
    checks++;
    if (bc !== m_bc(v) || ovf !== m_ovf(v) || err !== m_err(v)) begin
      failures++;
      $display("FAIL %s result v=%h got bc=%0d ovf=%b err=%b want bc=%0d ovf=%b err=%b",
               name, v, bc, ovf, err, m_bc(v), m_ovf(v), m_err(v));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bc !== 8'd0 || ovf !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got bc=%h ovf=%b err=%b busy=%b rdy=%b want all 0",
               bc, ovf, err, busy, rdy);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stable();
    int lat, nrdy, nbusy; bit bad;
    run_value(bdc, 30, lat, nrdy, nbusy, bad);
    checks++;
    if (nrdy !== 0 || nbusy !== 0) begin
      failures++;
      $display("FAIL stable_idle got rdy=%0d busy=%0d want 0 0", nrdy, nbusy);
    end
  endtask

  task automatic test_basic();
    int lat, nrdy, nbusy; bit bad;
    run_value(12'h042, 20, lat, nrdy, nbusy, bad);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL latency got=%0d want=14", lat);
    end
    checks++;
    if (nbusy < 11 || nbusy > 12) begin
      failures++;
      $display("FAIL busy_cycles got=%0d want=11..12", nbusy);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL basic_bc_stable got=changed want=unchanged_while_busy");
    end
    check_result("basic_042", 12'h042, nrdy);
    checks++;
    if (bc !== 8'd42) begin
      failures++;
      $display("FAIL basic_bc got=%0d want=42", bc);
    end
  endtask

  task automatic test_boundaries();
    logic [11:0] vals[5] = '{12'h255, 12'h256, 12'h999, 12'h000, 12'h001};
    int lat, nrdy, nbusy; bit bad;
    foreach (vals[i]) begin
      run_value(vals[i], 20, lat, nrdy, nbusy, bad);
      check_result("boundary", vals[i], nrdy);
    end
  endtask

  task automatic test_err();
    int lat, nrdy, nbusy; bit bad;
    run_value(12'h1A3, 20, lat, nrdy, nbusy, bad);
    check_result("err_1A3", 12'h1A3, nrdy);
    checks++;
    if (err !== 1'b1 || bc !== 8'd0) begin
      failures++;
      $display("FAIL err_flag got err=%b bc=%0d want err=1 bc=0", err, bc);
    end
    run_value(12'h123, 20, lat, nrdy, nbusy, bad);
    check_result("err_clear_123", 12'h123, nrdy);
  endtask

  task automatic test_restart();
    int nrdy;
    bit saw100;
    nrdy = 0; saw100 = 0;
    bdc = 12'h100;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 5) bdc = 12'h200;
      if (rdy) nrdy++;
      if (bc === 8'd100) saw100 = 1;
    end
    check_result("restart_200", 12'h200, nrdy);
    checks++;
    if (saw100) begin
      failures++;
      $display("FAIL restart_stale got bc=100_seen want=never_100");
    end
  endtask

  task automatic test_back_to_back();
    int nrdy;
    logic [11:0] last;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      last = to_bcd($urandom_range(0, 999));
      if (last == bdc) last = last ^ 12'h001;
      bdc = last;
      tick();
      if (rdy) nrdy++;
    end
    for (int e = 0; e < 30; e++) begin
      tick();
      if (rdy) nrdy++;
    end
    check_result("back_to_back", last, nrdy);
  endtask

  task automatic test_reset_abort();
    int nrdy, lat, nbusy; bit bad;
    nrdy = 0;
    bdc = 12'h099;
    // Capture at edge 3, step 6 completes at edge 9.
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (rdy) nrdy++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bc !== 8'd0 || ovf !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got bc=%h ovf=%b err=%b busy=%b rdy=%b want all 0",
               bc, ovf, err, busy, rdy);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      if (rdy) nrdy++;
    end
    rst = 1'b0;
    checks++;
    if (nrdy !== 0) begin
      failures++;
      $display("FAIL abort_rdy got=%0d want=0", nrdy);
    end
    run_value(12'h099, 20, lat, nrdy, nbusy, bad);
    check_result("after_reset_099", 12'h099, nrdy);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL after_reset_latency got=%0d want=14", lat);
    end
  endtask

  task automatic test_random();
    int lat, nrdy, nbusy; bit bad;
    logic [11:0] v;
    for (int i = 0; i < 40; i++) begin
      do begin
        if ($urandom_range(0, 3) == 0) v = 12'($urandom);
        else v = to_bcd($urandom_range(0, 999));
      end while (v == bdc);
      run_value(v, 20, lat, nrdy, nbusy, bad);
      check_result("random", v, nrdy);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL random_bc_stable v=%h got=changed want=unchanged_while_busy", v);
      end
    end
  endtask

  task automatic test_sweep();
    int lat, nrdy, nbusy; bit bad;
    logic [11:0] v;
    for (int n = 0; n < 1000; n++) begin
      v = to_bcd(n);
      if (v == bdc) v = to_bcd(n);  // equal only for repeats; still held, no pulse expected
      if (v == bdc) begin
        run_value(v, 20, lat, nrdy, nbusy, bad);
        continue;
      end
      run_value(v, 20, lat, nrdy, nbusy, bad);
      check_result("sweep", v, nrdy);
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_basic();
    test_boundaries();
    test_err();
    test_restart();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
